pi1_arbiter: RTL and testbench

- Round-robin arbiter that shares one pi1 slave port between MSTRCNT pi1 masters; typical slave is the device-table/reset-control block.
- Presents exactly one master's op/addr/data/sel to the slave per cycle.
- Returns registered read data and rdy only to the master that owns each transaction.
- Sits between core-side pi1 masters (cores, preloader DMA) and the shared device-table slave.

---
 rtl/pi1_arbiter.sv | 150 +++++++++++++++
 tb/tb_pi1_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pi1_arbiter.sv
// pi1_arbiter
//   Round-robin arbiter sharing one pi1 slave port between MSTRCNT pi1
//   masters. Exactly one master's op/addr/data/sel is presented to the
//   slave each cycle. Read data and rdy are steered back only to the
//   master that owns the transaction.
//
// Ports
//   clk_i, rst_ni  clock (rising edge) / asynchronous active-low reset
//   m_op_i         per-master op (00 NOOP, 01 WR, 10 RD, 11 RW), master i
//                  in bits [2i+1:2i]
//   m_addr_i       per-master word address
//   m_data_i       per-master write data
//   m_sel_i        per-master byte select
//   m_data_o       per-master read data (zero unless a response is owned)
//   m_rdy_o        per-master ready
//   m_mapsz_o      slave map size, broadcast to all masters
//   s_op_o         op to slave
//   s_addr_o       address to slave
//   s_data_o       write data to slave
//   s_sel_o        byte select to slave
//   s_data_i       slave read data, valid the cycle after acceptance
//   s_rdy_i        slave ready
//   s_mapsz_i      slave map size
module pi1_arbiter #(
    parameter int unsigned MSTRCNT   = 2,
    parameter int unsigned ARCHBITSZ = 32,
    parameter int unsigned ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [2*MSTRCNT-1:0]                 m_op_i,
    input  logic [ADDRBITSZ*MSTRCNT-1:0]         m_addr_i,
    input  logic [ARCHBITSZ*MSTRCNT-1:0]         m_data_i,
    input  logic [(ARCHBITSZ/8)*MSTRCNT-1:0]     m_sel_i,
    output logic [ARCHBITSZ*MSTRCNT-1:0]         m_data_o,
    output logic [MSTRCNT-1:0]                   m_rdy_o,
    output logic [ADDRBITSZ-1:0]                 m_mapsz_o,
    output logic [1:0]                           s_op_o,
    output logic [ADDRBITSZ-1:0]                 s_addr_o,
    output logic [ARCHBITSZ-1:0]                 s_data_o,
    output logic [ARCHBITSZ/8-1:0]               s_sel_o,
    input  logic [ARCHBITSZ-1:0]                 s_data_i,
    input  logic                                 s_rdy_i,
    input  logic [ADDRBITSZ-1:0]                 s_mapsz_i
);

    localparam int unsigned SELBITSZ = ARCHBITSZ/8;
    localparam int unsigned IDXW     = (MSTRCNT > 1) ? $clog2(MSTRCNT) : 1;

    typedef logic [IDXW-1:0] idx_t;

    idx_t ptr_q;    // round-robin start index
    idx_t hold_q;   // master presented last cycle
    idx_t owner_q;  // master owning the pending response
    logic rsp_q;    // response pending

    logic [MSTRCNT-1:0] req;
    logic               any_req;
    logic               found_hi;
    idx_t               pick_hi;
    idx_t               pick_lo;
    idx_t               pick;
    idx_t               cur;
    idx_t               ptr_nxt;
    logic [1:0]         cur_op;
    logic               cur_req;
    logic               accept;

    // Round-robin pick: the first requester at or above ptr_q wins; if none,
    // wrap around to the lowest-numbered requester.
    always_comb begin
        req      = '0;
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        any_req  = 1'b0;
        for (int unsigned i = 0; i < MSTRCNT; i++) begin
            req[i] = (m_op_i[2*i +: 2] != 2'b00);
            if (req[i] && !any_req) begin
                pick_lo = idx_t'(i);
                any_req = 1'b1;
            end
            if (req[i] && !found_hi && (idx_t'(i) >= ptr_q)) begin
                pick_hi  = idx_t'(i);
                found_hi = 1'b1;
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    // Slave-side selection and response steering. Reset is folded in
    // combinationally so the slave sees NOOP from the moment rst_ni drops.
    always_comb begin
        if (!rst_ni)
            cur = '0;
        else if (s_rdy_i && any_req)
            cur = pick;
        else
            cur = hold_q;

        cur_op   = '0;
        s_addr_o = m_addr_i[0 +: ADDRBITSZ];
        s_data_o = m_data_i[0 +: ARCHBITSZ];
        s_sel_o  = m_sel_i[0 +: SELBITSZ];
        for (int unsigned i = 0; i < MSTRCNT; i++) begin
            if (idx_t'(i) == cur) begin
                cur_op   = m_op_i[2*i +: 2];
                s_addr_o = m_addr_i[i*ADDRBITSZ +: ADDRBITSZ];
                s_data_o = m_data_i[i*ARCHBITSZ +: ARCHBITSZ];
                s_sel_o  = m_sel_i[i*SELBITSZ +: SELBITSZ];
            end
        end

        cur_req = rst_ni && (cur_op != 2'b00);
        s_op_o  = cur_req ? cur_op : 2'b00;
        accept  = s_rdy_i && cur_req;
        ptr_nxt = (cur == idx_t'(MSTRCNT-1)) ? '0 : cur + 1'b1;

        m_rdy_o  = '0;
        m_data_o = '0;
        for (int unsigned i = 0; i < MSTRCNT; i++) begin
            m_rdy_o[i] = s_rdy_i && ((accept && (idx_t'(i) == cur)) ||
                                     (rsp_q && (idx_t'(i) == owner_q)));
            if (rsp_q && (idx_t'(i) == owner_q))
                m_data_o[i*ARCHBITSZ +: ARCHBITSZ] = s_data_i;
        end
    end

    assign m_mapsz_o = s_mapsz_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= '0;
            hold_q  <= '0;
            owner_q <= '0;
            rsp_q   <= 1'b0;
        end else begin
            hold_q <= cur;
            if (accept) begin
                ptr_q   <= ptr_nxt;
                owner_q <= cur;
                rsp_q   <= cur_op[1];  // RD and RW expect read data back
            end else if (s_rdy_i) begin
                rsp_q <= 1'b0;
            end
            // s_rdy_i low: a pending response and its owner are held
        end
    end

endmodule

// File: tb/tb_pi1_arbiter.sv
module tb_pi1_arbiter;

    localparam int unsigned MSTRCNT   = 2;
    localparam int unsigned ARCHBITSZ = 32;
    localparam int unsigned ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8);
    localparam int unsigned SELBITSZ  = ARCHBITSZ/8;

    localparam logic [1:0] NOOP = 2'b00;
    localparam logic [1:0] WR   = 2'b01;
    localparam logic [1:0] RD   = 2'b10;
    localparam logic [1:0] RW   = 2'b11;

    localparam logic [ARCHBITSZ-1:0] M0_WD  = 32'hD0D0_0000;
    localparam logic [ARCHBITSZ-1:0] M1_WD  = 32'hD1D1_1111;
    localparam logic [SELBITSZ-1:0]  M0_SEL = 4'h3;
    localparam logic [SELBITSZ-1:0]  M1_SEL = 4'hC;
    localparam logic [ADDRBITSZ-1:0] MAPSZ  = 30'h0000_1234;

    logic                              clk_i = 1'b0;
    logic                              rst_ni;
    logic [2*MSTRCNT-1:0]              m_op_i;
    logic [ADDRBITSZ*MSTRCNT-1:0]      m_addr_i;
    logic [ARCHBITSZ*MSTRCNT-1:0]      m_data_i;
    logic [SELBITSZ*MSTRCNT-1:0]       m_sel_i;
    logic [ARCHBITSZ*MSTRCNT-1:0]      m_data_o;
    logic [MSTRCNT-1:0]                m_rdy_o;
    logic [ADDRBITSZ-1:0]              m_mapsz_o;
    logic [1:0]                        s_op_o;
    logic [ADDRBITSZ-1:0]              s_addr_o;
    logic [ARCHBITSZ-1:0]              s_data_o;
    logic [SELBITSZ-1:0]               s_sel_o;
    logic [ARCHBITSZ-1:0]              s_data_i;
    logic                              s_rdy_i;
    logic [ADDRBITSZ-1:0]              s_mapsz_i;

    logic [1:0]           m0_op, m1_op;
    logic [ADDRBITSZ-1:0] m0_addr, m1_addr;

    assign m_op_i   = {m1_op, m0_op};
    assign m_addr_i = {m1_addr, m0_addr};
    assign m_data_i = {M1_WD, M0_WD};
    assign m_sel_i  = {M1_SEL, M0_SEL};

    pi1_arbiter #(
        .MSTRCNT   (MSTRCNT),
        .ARCHBITSZ (ARCHBITSZ),
        .ADDRBITSZ (ADDRBITSZ)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .m_op_i    (m_op_i),
        .m_addr_i  (m_addr_i),
        .m_data_i  (m_data_i),
        .m_sel_i   (m_sel_i),
        .m_data_o  (m_data_o),
        .m_rdy_o   (m_rdy_o),
        .m_mapsz_o (m_mapsz_o),
        .s_op_o    (s_op_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_sel_o   (s_sel_o),
        .s_data_i  (s_data_i),
        .s_rdy_i   (s_rdy_i),
        .s_mapsz_i (s_mapsz_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string                tag;
        logic [1:0]           op;
        logic                 show;   // compare addr/data/sel of master idx
        logic [ADDRBITSZ-1:0] addr;
        logic [ARCHBITSZ-1:0] wd;
        logic [SELBITSZ-1:0]  sel;
        logic [MSTRCNT-1:0]   rdy;
        logic [ARCHBITSZ-1:0] d0;
        logic [ARCHBITSZ-1:0] d1;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] o0, input logic [ADDRBITSZ-1:0] a0,
                         input logic [1:0] o1, input logic [ADDRBITSZ-1:0] a1,
                         input logic rdy, input logic [ARCHBITSZ-1:0] sd);
        m0_op    = o0;
        m0_addr  = a0;
        m1_op    = o1;
        m1_addr  = a1;
        s_rdy_i  = rdy;
        s_data_i = sd;
    endtask

    // Expected slave-side fields are taken from the stimulus of master idx.
    task automatic push(input string tag, input logic [1:0] op, input logic show,
                        input int idx, input logic [MSTRCNT-1:0] rdy,
                        input logic [ARCHBITSZ-1:0] d0, input logic [ARCHBITSZ-1:0] d1);
        exp_t e;
        e.tag  = tag;
        e.op   = op;
        e.show = show;
        e.addr = (idx == 1) ? m1_addr : m0_addr;
        e.wd   = (idx == 1) ? M1_WD : M0_WD;
        e.sel  = (idx == 1) ? M1_SEL : M0_SEL;
        e.rdy  = rdy;
        e.d0   = d0;
        e.d1   = d1;
        sb_q.push_back(e);
    endtask

    // Outputs are compared at the falling edge, inputs change 1 time unit
    // after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk_i);
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, ".op"},  64'(s_op_o),  64'(e.op));
            check({e.tag, ".rdy"}, 64'(m_rdy_o), 64'(e.rdy));
            check({e.tag, ".d0"},  64'(m_data_o[0 +: ARCHBITSZ]), 64'(e.d0));
            check({e.tag, ".d1"},  64'(m_data_o[ARCHBITSZ +: ARCHBITSZ]), 64'(e.d1));
            if (e.show) begin
                check({e.tag, ".addr"}, 64'(s_addr_o), 64'(e.addr));
                check({e.tag, ".wd"},   64'(s_data_o), 64'(e.wd));
                check({e.tag, ".sel"},  64'(s_sel_o),  64'(e.sel));
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int cur;
        logic [MSTRCNT-1:0]   rdy;
        logic [ARCHBITSZ-1:0] sd, d0, d1;

        rst_ni    = 1'b0;
        s_mapsz_i = MAPSZ;
        drive(NOOP, 30'd0, NOOP, 30'd0, 1'b1, 32'h0);
        #1;

        // reset state
        push("rst0", NOOP, 1'b1, 0, 2'b00, 32'h0, 32'h0); tick();
        push("rst1", NOOP, 1'b1, 0, 2'b00, 32'h0, 32'h0); tick();
        rst_ni = 1'b1;
        check("mapsz", 64'(m_mapsz_o), 64'(MAPSZ));

        // single read by m0
        drive(RD, 30'd4, NOOP, 30'd0, 1'b1, 32'h0);
        push("rd.c0", RD, 1'b1, 0, 2'b01, 32'h0, 32'h0); tick();
        drive(NOOP, 30'd4, NOOP, 30'd0, 1'b1, 32'h1);
        push("rd.c1", NOOP, 1'b0, 0, 2'b01, 32'h1, 32'h0); tick();

        // write: no response cycle afterwards
        drive(WR, 30'd8, NOOP, 30'd0, 1'b1, 32'h0);
        push("wr.c0", WR, 1'b1, 0, 2'b01, 32'h0, 32'h0); tick();
        drive(NOOP, 30'd8, NOOP, 30'd0, 1'b1, 32'h55);
        push("wr.c1", NOOP, 1'b0, 0, 2'b00, 32'h0, 32'h0); tick();

        // RW by m1, response stalled one cycle then delivered to m1 only
        drive(NOOP, 30'd0, RW, 30'd0, 1'b1, 32'h0);
        push("rw.c0", RW, 1'b1, 1, 2'b10, 32'h0, 32'h0); tick();
        drive(NOOP, 30'd0, NOOP, 30'd0, 1'b0, 32'h33);
        push("rw.stall", NOOP, 1'b0, 1, 2'b00, 32'h0, 32'h33); tick();
        drive(NOOP, 30'd0, NOOP, 30'd0, 1'b1, 32'hA5);
        push("rw.c1", NOOP, 1'b0, 1, 2'b10, 32'h0, 32'hA5); tick();

        // m1 WR held on the slave through a 3-cycle stall
        for (int i = 0; i < 3; i++) begin
            drive(NOOP, 30'd0, WR, 30'd12, 1'b0, 32'h0);
            push("stall", WR, 1'b1, 1, 2'b00, 32'h0, 32'h0); tick();
        end
        drive(NOOP, 30'd0, WR, 30'd12, 1'b1, 32'h0);
        push("stall.acc", WR, 1'b1, 1, 2'b10, 32'h0, 32'h0); tick();
        drive(RD, 30'd16, NOOP, 30'd12, 1'b1, 32'h0);
        push("stall.m0", RD, 1'b1, 0, 2'b01, 32'h0, 32'h0); tick();
        drive(NOOP, 30'd16, NOOP, 30'd12, 1'b1, 32'h77);
        push("stall.rsp", NOOP, 1'b0, 0, 2'b01, 32'h77, 32'h0); tick();

        // pointer now at m1: with both requesting, m1 goes first
        drive(RD, 30'd20, RD, 30'd24, 1'b1, 32'h0);
        push("ptr1", RD, 1'b1, 1, 2'b10, 32'h0, 32'h0); tick();

        // asynchronous reset between accept and response edge
        drive(RD, 30'd20, NOOP, 30'd24, 1'b1, 32'h99);
        rst_ni = 1'b0;
        push("arst", NOOP, 1'b1, 0, 2'b00, 32'h0, 32'h0); tick();
        drive(RD, 30'd20, RD, 30'd24, 1'b1, 32'h99);
        push("arst.hold", NOOP, 1'b1, 0, 2'b00, 32'h0, 32'h0); tick();
        rst_ni = 1'b1;

        // contention from reset: accepts alternate m0, m1, ...
        for (int k = 0; k < 6; k++) begin
            sd  = 32'h100 + 32'(k);
            cur = k % 2;
            rdy = (k == 0) ? MSTRCNT'(1 << cur) : 2'b11;
            d0  = (k > 0 && cur == 1) ? sd : 32'h0;
            d1  = (k > 0 && cur == 0) ? sd : 32'h0;
            drive(RD, 30'd20, RD, 30'd24, 1'b1, sd);
            push($sformatf("rr%0d", k), RD, 1'b1, cur, rdy, d0, d1); tick();
        end

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
